tl_ul_scratchpad: RTL and testbench
===================================

TL_UL_SCRATCHPAD -- requirements
Module: tl_ul_scratchpad

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 30'h0000_0000, meaning byte base address of the 64-byte window (64-byte aligned).
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of 32-bit words; fixed at 16, window = 64 bytes.
REQ-003 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have A-channel inputs: a_valid 1, a_opcode 3, a_param 3, a_size 3, a_source 2, a_address 30, a_mask 4, a_data 32.
REQ-006 SHALL have output a_ready  1  A beat accepted when a_valid && a_ready.
REQ-007 SHALL have D-channel outputs: d_valid 1, d_opcode 3, d_param 2, d_size 3, d_source 2, d_denied 1, d_data 32, d_corrupt 1.
REQ-008 SHALL have input d_ready  1  D beat consumed when d_valid && d_ready.

Function
REQ-009 SHALL be a TileLink-UL single-beat slave that drives the A/D channels observed by the TL monitor assertion wrapper.
REQ-010 SHALL hold a 2-entry response FIFO: wr_ptr, rd_ptr 1 bit each; count 2 bits (0..2).
REQ-011 SHALL drive a_ready = (count != 2) outside reset; no same-cycle bypass of a full FIFO.
REQ-012 SHALL drive d_valid = (count != 0); D fields come from the FIFO head and stay stable while d_valid && !d_ready.
REQ-013 SHALL update count as: push only +1, pop only -1, push and pop together unchanged; pointers wrap 1->0.
REQ-014 SHALL give a request one-cycle minimum latency: accepted at edge N, D valid from cycle N+1.
REQ-015 SHALL decode legal = opcode in {0 PutFull, 1 PutPartial, 4 Get} && a_size <= 2 && address aligned to 2^a_size && BASE_ADDR <= a_address < BASE_ADDR+64.
REQ-016 SHALL on legal Put accept: write each byte lane i of word a_address[5:2] where a_mask[i]=1, in the accept cycle; queue d_opcode=0 (AccessAck).
REQ-017 SHALL on legal Get accept: capture the full 32-bit word a_address[5:2] (including a write accepted in an earlier cycle); queue d_opcode=1 (AccessAckData), d_data=word.
REQ-018 SHALL on illegal accept: perform no write; queue d_denied=1, d_data=0, d_opcode=1 if a_opcode==4 else 0.
REQ-019 SHALL set d_corrupt = d_denied for AccessAckData and 0 for AccessAck; d_param = 0 always.
REQ-020 SHALL echo a_size into d_size and a_source into d_source; responses return in acceptance order.
REQ-021 SHALL ignore a_param and all A inputs when a_valid=0.
REQ-022 SHALL never issue two D beats for one A beat and never drop an accepted request.

Reset
REQ-023 SHALL, while reset=1: count=0, pointers=0, d_valid=0, a_ready=0, all D outputs 0, all 16 memory words 0.
REQ-024 SHALL assert a_ready=1 in the first cycle after reset deasserts.
REQ-025 SHALL, on reset asserted mid-operation, discard queued responses and partial state immediately (asynchronously).

Verification
REQ-026 Put then Get: PutFull addr BASE+0x8, size 2, mask F, data 0xDEADBEEF, src 1; then Get BASE+0x8 src 2 -> AccessAck src 1, then AccessAckData data 0xDEADBEEF src 2, denied 0.
REQ-027 PutPartial mask 4'b0101 data 0x11223344 to word holding 0 -> later Get returns 0x00220044.
REQ-028 Back-pressure: d_ready=0, issue 3 Gets -> first two accepted, a_ready=0 on third, D fields stable; d_ready=1 -> third accepted next cycle, order preserved.
REQ-029 Illegal: Get BASE+0x40; PutFull size 3; opcode 2; Get BASE+0x2 size 2 -> all denied=1, data 0, memory unchanged, d_corrupt=1 only for the Get cases.
REQ-030 Simultaneous push/pop at count=1 every cycle for 10 cycles -> count stays 1, throughput 1 beat/cycle.
REQ-031 Assert reset with count=2 -> d_valid=0 immediately, a_ready=1 one cycle after release, subsequent Get of any word returns 0.

Source files
------------

// File: rtl/tl_ul_scratchpad.sv
// TileLink-UL single-beat slave backed by a 16-word byte-maskable scratchpad.
// Responses queue in a 2-entry FIFO so A and D can proceed at one beat per cycle.
module tl_ul_scratchpad #(
  parameter logic [29:0] BASE_ADDR = 30'h0000_0000,
  parameter int          DEPTH     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [1:0]  a_source,
  input  logic [29:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  output logic        a_ready,
  output logic        d_valid,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [2:0]  d_size,
  output logic [1:0]  d_source,
  output logic        d_denied,
  output logic [31:0] d_data,
  output logic        d_corrupt,
  input  logic        d_ready
);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [1:0]  source;
    logic        denied;
    logic [31:0] data;
  } rsp_t;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  logic [31:0] mem [DEPTH];
  rsp_t        fifo [2];
  rsp_t        head;
  rsp_t        rsp_new;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic        is_get;
  logic        is_put;
  logic        size_ok;
  logic        align_ok;
  logic        in_window;
  logic        legal;
  logic [3:0]  idx;
  logic        unused_a;

  assign unused_a = ^a_param;
  assign idx      = a_address[5:2];

  // reset gates a_ready directly so no beat is taken while it is held
  assign a_ready = ~reset & (count != 2'd2);
  assign d_valid = (count != 2'd0);
  assign push    = a_valid & a_ready;
  assign pop     = d_valid & d_ready;

  always_comb begin
    is_get    = (a_opcode == OP_GET);
    is_put    = (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PART);
    size_ok   = (a_size <= 3'd2);
    in_window = (a_address[29:6] == BASE_ADDR[29:6]);
    align_ok  = 1'b0;
    unique case (1'b1)
      a_size == 3'd0: align_ok = 1'b1;
      a_size == 3'd1: align_ok = ~a_address[0];
      a_size == 3'd2: align_ok = (a_address[1:0] == 2'b00);
      default:        align_ok = 1'b0;
    endcase
    legal = (is_get | is_put) & size_ok & align_ok & in_window;

    rsp_new        = '0;
    rsp_new.opcode = is_get ? OP_ACK_DATA : OP_ACK;
    rsp_new.size   = a_size;
    rsp_new.source = a_source;
    rsp_new.denied = ~legal;
    rsp_new.data   = (legal & is_get) ? mem[idx] : 32'h0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= rsp_new;
        wr_ptr       <= ~wr_ptr;
        if (legal & is_put) begin
          for (int b = 0; b < 4; b++) begin
            if (a_mask[b]) mem[idx][8*b +: 8] <= a_data[8*b +: 8];
          end
        end
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head      = fifo[rd_ptr];
  assign d_opcode  = head.opcode;
  assign d_param   = 2'd0;
  assign d_size    = head.size;
  assign d_source  = head.source;
  assign d_denied  = head.denied;
  assign d_data    = head.data;
  assign d_corrupt = head.denied & (head.opcode == OP_ACK_DATA);

endmodule

// File: tb/tb_tl_ul_scratchpad.sv
// Directed and random TileLink-UL traffic against a queue/array reference model.
module tb_tl_ul_scratchpad;

  localparam logic [29:0] BASE = 30'h0000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [2:0]  a_size = '0;
  logic [1:0]  a_source = '0;
  logic [29:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [1:0]  d_source;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;
  logic        d_ready = 1'b0;

  tl_ul_scratchpad #(.BASE_ADDR(BASE), .DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address),
    .a_mask(a_mask), .a_data(a_data), .a_ready(a_ready),
    .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt), .d_ready(d_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned op;
    int unsigned sz;
    int unsigned src;
    int unsigned den;
    int unsigned data;
  } rsp_t;

  int   vectors = 0;
  int   miscompares = 0;
  rsp_t q[$];
  int unsigned m[16];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < 16; i++) m[i] = 0;
  endfunction

  task automatic cyc(input bit v, input int unsigned op, input int unsigned sz,
                     input int unsigned src, input int unsigned addr,
                     input int unsigned mask, input int unsigned data, input bit dr);
    int   had;
    bit   legal;
    int unsigned idx;
    rsp_t r;
    @(negedge clock);
    a_valid   = v;
    a_opcode  = op[2:0];
    a_param   = 3'($urandom_range(0, 7));
    a_size    = sz[2:0];
    a_source  = src[1:0];
    a_address = addr[29:0];
    a_mask    = mask[3:0];
    a_data    = data;
    d_ready   = dr;
    #1;
    had = q.size();
    check("a_ready", 32'(a_ready), (had < 2) ? 1 : 0);
    check("d_valid", 32'(d_valid), (had > 0) ? 1 : 0);
    check("d_param", 32'(d_param), 0);
    if (had > 0) begin
      check("d_opcode", 32'(d_opcode), q[0].op);
      check("d_size", 32'(d_size), q[0].sz);
      check("d_source", 32'(d_source), q[0].src);
      check("d_denied", 32'(d_denied), q[0].den);
      check("d_data", d_data, q[0].data);
      check("d_corrupt", 32'(d_corrupt), (q[0].op == 1) ? q[0].den : 0);
    end
    if (dr && had > 0) void'(q.pop_front());
    if (v && had < 2) begin
      legal = (op == 0 || op == 1 || op == 4) && sz <= 2 &&
              (addr % (1 << sz)) == 0 &&
              addr >= 32'(BASE) && addr < 32'(BASE) + 64;
      idx    = (addr - 32'(BASE)) / 4;
      r.op   = (op == 4) ? 1 : 0;
      r.sz   = sz;
      r.src  = src;
      r.den  = legal ? 0 : 1;
      r.data = (legal && op == 4) ? m[idx] : 0;
      if (legal && op != 4) begin
        for (int b = 0; b < 4; b++) begin
          if (mask[b]) begin
            m[idx] = (m[idx] & ~(32'hFF << (8 * b))) | (data & (32'hFF << (8 * b)));
          end
        end
      end
      q.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int unsigned op, sz, addr;
    model_reset();
    #12;
    check("rst_a_ready", 32'(a_ready), 0);
    check("rst_d_valid", 32'(d_valid), 0);
    check("rst_d_opcode", 32'(d_opcode), 0);
    check("rst_d_data", d_data, 0);
    check("rst_d_source", 32'(d_source), 0);
    check("rst_d_size", 32'(d_size), 0);
    check("rst_d_denied", 32'(d_denied), 0);
    @(negedge clock);
    reset = 1'b0;

    // put then get
    cyc(1, 0, 2, 1, 32'(BASE) + 8, 4'hF, 32'hDEADBEEF, 1);
    cyc(1, 4, 2, 2, 32'(BASE) + 8, 0, 0, 1);
    idle(3);

    // partial put into a zero word
    cyc(1, 1, 2, 0, 32'(BASE) + 16, 4'b0101, 32'h11223344, 1);
    cyc(1, 4, 2, 3, 32'(BASE) + 16, 0, 0, 1);
    idle(2);

    // back-pressure: third Get waits for space
    cyc(1, 4, 2, 1, 32'(BASE) + 8, 0, 0, 0);
    cyc(1, 4, 2, 2, 32'(BASE) + 16, 0, 0, 0);
    cyc(1, 4, 2, 3, 32'(BASE) + 0, 0, 0, 0);
    cyc(1, 4, 2, 3, 32'(BASE) + 0, 0, 0, 0);
    cyc(1, 4, 2, 3, 32'(BASE) + 0, 0, 0, 1);
    cyc(1, 4, 2, 3, 32'(BASE) + 0, 0, 0, 1);
    idle(3);

    // illegal requests, then confirm memory intact
    cyc(1, 4, 2, 0, 32'(BASE) + 64, 0, 0, 1);
    cyc(1, 0, 3, 1, 32'(BASE) + 8, 4'hF, 32'hFFFFFFFF, 1);
    cyc(1, 2, 2, 2, 32'(BASE) + 8, 4'hF, 32'hFFFFFFFF, 1);
    cyc(1, 4, 2, 3, 32'(BASE) + 2, 0, 0, 1);
    cyc(1, 0, 2, 0, 32'(BASE) - 4, 4'hF, 32'h12345678, 1);
    cyc(1, 4, 2, 1, 32'(BASE) + 8, 0, 0, 1);
    cyc(1, 4, 1, 2, 32'(BASE) + 17, 0, 0, 1);
    cyc(1, 4, 0, 2, 32'(BASE) + 17, 0, 0, 1);
    idle(3);

    // steady-state push and pop at one beat per cycle
    cyc(1, 4, 2, 0, 32'(BASE) + 8, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(1, (i % 2 == 0) ? 4 : 0, 2, 32'(i % 4), 32'(BASE) + 32'(4 * i),
          4'hF, 32'hA5A50000 + 32'(i), 1);
    idle(3);

    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 5))
        0: op = 0;
        1: op = 1;
        2, 3: op = 4;
        default: op = $urandom_range(0, 7);
      endcase
      sz   = ($urandom_range(0, 3) != 0) ? 2 : $urandom_range(0, 3);
      addr = 32'(BASE) - 8 + $urandom_range(0, 79);
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 1);
      cyc($urandom_range(0, 3) != 0, op, sz, $urandom_range(0, 3), addr,
          $urandom_range(0, 15), $urandom, $urandom_range(0, 3) != 0);
    end

    // fill the FIFO then reset mid-operation
    cyc(1, 4, 2, 1, 32'(BASE) + 8, 0, 0, 0);
    cyc(1, 4, 2, 2, 32'(BASE) + 12, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("arst_d_valid", 32'(d_valid), 0);
    check("arst_a_ready", 32'(a_ready), 0);
    check("arst_d_data", d_data, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int w = 0; w < 16; w++) cyc(1, 4, 2, 32'(w % 4), 32'(BASE) + 32'(4 * w), 0, 0, 1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
